// File: rtl/ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg
//   EX/MEM pipeline register of the 5-stage MIPS core. Captures E-stage
//   results and control every cycle and presents them to the M stage and to
//   the M-source forwarding comparators. It also tracks Tnew, the number of
//   cycles until the held instruction's result exists, so the hazard unit can
//   choose between forwarding and stalling.
//
//   Update priority on each rising edge: reset > FlushM > StallM > load.
//   A stall freezes every field except Tnew, which keeps counting down
//   because the held instruction's result keeps maturing.
//
// Parameters
//   DATA_W : datapath width (instruction, PC+8, ALU result, store data)
//   REG_AW : register-file address width
//   TNEW_W : width of the Tnew field
//
// Ports
//   clk, reset                 : core clock, synchronous active-high reset
//   StallM, FlushM             : hold / bubble the M stage
//   InstrE..TnewE              : E-stage values to capture
//   InstrM..TnewM              : registered M-stage values
//   FwdOkM                     : M-stage result may be forwarded now
//   BubbleCnt, StallCnt        : performance counters (EXMEM_PERF_EN only)
//
// Configuration
//   EXMEM_PERF_EN : when defined, adds 32-bit BubbleCnt / StallCnt counters.
// ---------------------------------------------------------------------------
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic [DATA_W-1:0] InstrE,
  input  logic [DATA_W-1:0] PC8E,
  input  logic [DATA_W-1:0] ALUOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemtoRegE,
  input  logic [TNEW_W-1:0] TnewE,
  output logic [DATA_W-1:0] InstrM,
  output logic [DATA_W-1:0] PC8M,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_AW-1:0] WriteRegM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemtoRegM,
  output logic [TNEW_W-1:0] TnewM,
  output logic              FwdOkM
`ifdef EXMEM_PERF_EN
  ,
  output logic [31:0]       BubbleCnt,
  output logic [31:0]       StallCnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc8;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] write_data;
    logic [REG_AW-1:0] write_reg;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic [TNEW_W-1:0] tnew;
  } m_stage_t;

  m_stage_t m_q, m_d;

  // One cycle closer to the result, never below zero.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  always_comb begin
    // NOTE: m_d gets a full default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    m_d = m_q;
    if (FlushM) begin
      m_d = '0;
    end else if (StallM) begin
      m_d.tnew = tnew_dec(m_q.tnew);
    end else begin
      m_d.instr      = InstrE;
      m_d.pc8        = PC8E;
      m_d.alu_out    = ALUOutE;
      m_d.write_data = WriteDataE;
      m_d.write_reg  = WriteRegE;
      // Writes to $0 are dropped here so downstream comparators never match on $0.
      m_d.reg_write  = RegWriteE && (WriteRegE != '0);
      m_d.mem_write  = MemWriteE;
      m_d.mem_to_reg = MemtoRegE;
      m_d.tnew       = tnew_dec(TnewE);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all registered state so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) begin
      m_q <= '0;
    end else begin
      m_q <= m_d;
    end
  end

  assign InstrM     = m_q.instr;
  assign PC8M       = m_q.pc8;
  assign ALUOutM    = m_q.alu_out;
  assign WriteDataM = m_q.write_data;
  assign WriteRegM  = m_q.write_reg;
  assign RegWriteM  = m_q.reg_write;
  assign MemWriteM  = m_q.mem_write;
  assign MemtoRegM  = m_q.mem_to_reg;
  assign TnewM      = m_q.tnew;
  assign FwdOkM     = m_q.reg_write && (m_q.write_reg != '0) && (m_q.tnew == '0);

`ifdef EXMEM_PERF_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] stall_cnt_q;

  // A flush that coincides with a stall counts as a bubble only.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else if (FlushM) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end else if (StallM) begin
      stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign BubbleCnt = bubble_cnt_q;
  assign StallCnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
//   Self-checking bench for ex_mem_pipe_reg: directed scenarios followed by
//   randomized reset/flush/stall/load traffic, compared each cycle against a
//   behavioural model of the M stage.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int TNEW_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              StallM, FlushM;
  logic [DATA_W-1:0] InstrE, PC8E, ALUOutE, WriteDataE;
  logic [REG_AW-1:0] WriteRegE;
  logic              RegWriteE, MemWriteE, MemtoRegE;
  logic [TNEW_W-1:0] TnewE;
  logic [DATA_W-1:0] InstrM, PC8M, ALUOutM, WriteDataM;
  logic [REG_AW-1:0] WriteRegM;
  logic              RegWriteM, MemWriteM, MemtoRegM;
  logic [TNEW_W-1:0] TnewM;
  logic              FwdOkM;
`ifdef EXMEM_PERF_EN
  logic [31:0]       BubbleCnt, StallCnt;
  int unsigned       mdl_bubble, mdl_stall;
`endif

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TNEW_W(TNEW_W)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
    .InstrE(InstrE), .PC8E(PC8E), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .MemtoRegE(MemtoRegE), .TnewE(TnewE),
    .InstrM(InstrM), .PC8M(PC8M), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemtoRegM(MemtoRegM), .TnewM(TnewM), .FwdOkM(FwdOkM)
`ifdef EXMEM_PERF_EN
    , .BubbleCnt(BubbleCnt), .StallCnt(StallCnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Behavioural model of what the M stage should hold.
  int unsigned mdl_instr, mdl_pc8, mdl_alu, mdl_wd;
  int unsigned mdl_wr, mdl_rw, mdl_mw, mdl_mtr, mdl_tnew;

  task automatic model_clear();
    mdl_instr = 0; mdl_pc8 = 0; mdl_alu = 0; mdl_wd = 0;
    mdl_wr = 0; mdl_rw = 0; mdl_mw = 0; mdl_mtr = 0; mdl_tnew = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_clear();
`ifdef EXMEM_PERF_EN
      mdl_bubble = 0; mdl_stall = 0;
`endif
    end else if (FlushM) begin
      model_clear();
`ifdef EXMEM_PERF_EN
      mdl_bubble = mdl_bubble + 1;
`endif
    end else if (StallM) begin
      mdl_tnew = (mdl_tnew > 0) ? mdl_tnew - 1 : 0;
`ifdef EXMEM_PERF_EN
      mdl_stall = mdl_stall + 1;
`endif
    end else begin
      mdl_instr = InstrE; mdl_pc8 = PC8E; mdl_alu = ALUOutE; mdl_wd = WriteDataE;
      mdl_wr   = WriteRegE;
      mdl_rw   = (RegWriteE && WriteRegE != 0) ? 1 : 0;
      mdl_mw   = MemWriteE;
      mdl_mtr  = MemtoRegE;
      mdl_tnew = (TnewE > 0) ? TnewE - 1 : 0;
    end
  endtask

  task automatic check_model(input string tag);
    int unsigned fwd;
    fwd = (mdl_rw != 0 && mdl_wr != 0 && mdl_tnew == 0) ? 1 : 0;
    check({tag, ".InstrM"},     64'(InstrM),     64'(mdl_instr));
    check({tag, ".PC8M"},       64'(PC8M),       64'(mdl_pc8));
    check({tag, ".ALUOutM"},    64'(ALUOutM),    64'(mdl_alu));
    check({tag, ".WriteDataM"}, 64'(WriteDataM), 64'(mdl_wd));
    check({tag, ".WriteRegM"},  64'(WriteRegM),  64'(mdl_wr));
    check({tag, ".RegWriteM"},  64'(RegWriteM),  64'(mdl_rw));
    check({tag, ".MemWriteM"},  64'(MemWriteM),  64'(mdl_mw));
    check({tag, ".MemtoRegM"},  64'(MemtoRegM),  64'(mdl_mtr));
    check({tag, ".TnewM"},      64'(TnewM),      64'(mdl_tnew));
    check({tag, ".FwdOkM"},     64'(FwdOkM),     64'(fwd));
`ifdef EXMEM_PERF_EN
    check({tag, ".BubbleCnt"},  64'(BubbleCnt),  64'(mdl_bubble));
    check({tag, ".StallCnt"},   64'(StallCnt),   64'(mdl_stall));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".zero.Instr/PC8"}, {InstrM, PC8M}, 64'd0);
    check({tag, ".zero.ALU/WD"},    {ALUOutM, WriteDataM}, 64'd0);
    check({tag, ".zero.ctrl"},
          64'({WriteRegM, RegWriteM, MemWriteM, MemtoRegM, TnewM, FwdOkM}), 64'd0);
  endtask

  // Advance one edge, update the model, then sample outputs away from the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic set_e(input logic [31:0] instr, input logic [31:0] pc8,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input logic rw, input logic mw,
                       input logic mtr, input logic [1:0] tnew);
    InstrE = instr; PC8E = pc8; ALUOutE = alu; WriteDataE = wd;
    WriteRegE = wr; RegWriteE = rw; MemWriteE = mw; MemtoRegE = mtr; TnewE = tnew;
  endtask

  task automatic set_e_random();
    set_e($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    model_clear();
`ifdef EXMEM_PERF_EN
    mdl_bubble = 0; mdl_stall = 0;
`endif
    reset = 1'b1; StallM = 1'b0; FlushM = 1'b0;
    set_e(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Reset held for two edges.
    tick("rst0");
    tick("rst1");
    check_all_zero("rst");

    // First load after reset.
    reset = 1'b0;
    set_e(32'h0085_1020, 32'h0000_0008, 32'h0000_1234, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 2'd0);
    tick("load");
    check("load.WriteRegM", 64'(WriteRegM), 64'd2);
    check("load.RegWriteM", 64'(RegWriteM), 64'd1);
    check("load.ALUOutM",   64'(ALUOutM),   64'h1234);
    check("load.TnewM",     64'(TnewM),     64'd0);
    check("load.FwdOkM",    64'(FwdOkM),    64'd1);

    // Writes to $0 become non-writes.
    set_e(32'h0000_0820, 32'h0000_000C, 32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick("zero_reg");
    check("zero_reg.RegWriteM", 64'(RegWriteM), 64'd0);
    check("zero_reg.FwdOkM",    64'(FwdOkM),    64'd0);

    // Load-use: Tnew matures while stalled.
    set_e(32'h8C88_0000, 32'h0000_0010, 32'h0000_ABCD, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 2'd2);
    tick("lw");
    check("lw.TnewM",  64'(TnewM),  64'd1);
    check("lw.FwdOkM", 64'(FwdOkM), 64'd0);
    StallM = 1'b1;
    set_e_random();
    tick("lw_stall1");
    check("lw_stall1.TnewM",   64'(TnewM),   64'd0);
    check("lw_stall1.FwdOkM",  64'(FwdOkM),  64'd1);
    check("lw_stall1.ALUOutM", 64'(ALUOutM), 64'hABCD);
    tick("lw_stall2");
    check("lw_stall2.TnewM",   64'(TnewM),   64'd0);
    check("lw_stall2.ALUOutM", 64'(ALUOutM), 64'hABCD);

    // Flush beats a simultaneous stall.
    FlushM = 1'b1;
    set_e(32'h0123_4567, 32'h20, 32'h99, 32'h77, 5'd9, 1'b1, 1'b1, 1'b1, 2'd1);
    tick("flush_stall");
    check_all_zero("flush_stall");

    // Reset during a stall.
    FlushM = 1'b0; StallM = 1'b0;
    set_e(32'h0000_2820, 32'h24, 32'h42, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd1);
    tick("pre_rst");
    StallM = 1'b1;
    set_e_random();
    tick("hold5");
    check("hold5.WriteRegM", 64'(WriteRegM), 64'd5);
    reset = 1'b1;
    tick("rst_stall");
    check_all_zero("rst_stall");
    reset = 1'b0; StallM = 1'b0;

    // Bubble / stall accounting: 3 flushes then 4 stall-only edges.
    FlushM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_e_random();
      tick("perf_flush");
    end
    FlushM = 1'b0; StallM = 1'b1;
    for (int i = 0; i < 4; i++) tick("perf_stall");
`ifdef EXMEM_PERF_EN
    check("perf.BubbleCnt", 64'(BubbleCnt), 64'd3);
    check("perf.StallCnt",  64'(StallCnt),  64'd4);
`endif
    reset = 1'b1;
    tick("perf_rst");
`ifdef EXMEM_PERF_EN
    check("perf_rst.BubbleCnt", 64'(BubbleCnt), 64'd0);
    check("perf_rst.StallCnt",  64'(StallCnt),  64'd0);
`endif
    reset = 1'b0; StallM = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 99) < 2);
      FlushM = ($urandom_range(0, 99) < 10);
      StallM = ($urandom_range(0, 99) < 25);
      set_e_random();
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
